regfile_dump_ctrl: RTL and testbench

Sequencer that takes over the register file's A read port after a program run and streams every architectural register out, one register per beat, over a valid/ready interface. It sits between the processor's ctrl_readRegA and the regfile read-address input. It replaces ad-hoc register-scan loops with a synthesizable, reusable block for bench result checking and an on-board result dump over UART/display. When idle it is a transparent pass-through for the processor's read address.

---
 rtl/regfile_dump_ctrl_pkg.sv | 13 +
 rtl/regfile_dump_ctrl.sv | 120 ++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared types and widths for the register-file dump sequencer.
package regfile_dump_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Hijacks the regfile A read port when busy and streams registers out over valid/ready;
// transparent pass-through of the processor read address when idle.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int FIRST_REG     = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [REG_ADDR_W-1:0] proc_rs1,
  output logic [REG_ADDR_W-1:0] rs1_out,
  input  logic [DATA_W-1:0]     regA_in,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [REG_ADDR_W-1:0] dump_reg,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  busy,
  output logic                  done
);

  if (NUM_REGS < 1 || NUM_REGS > 32 || FIRST_REG < 0 || FIRST_REG >= NUM_REGS ||
      SETTLE_CYCLES < 1) begin : g_param_check
    $error("regfile_dump_ctrl: illegal parameter combination");
  end

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  dump_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [REG_ADDR_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    reg_d   = reg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    // abort overrides everything, including a handshake on the same edge
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      idx_d   = FIRST_IDX;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_d   = FIRST_IDX;
            cnt_d   = '0;
            state_d = ADDR;
          end
        end
        ADDR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            data_d  = regA_in;
            reg_d   = idx_q;
            valid_d = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          if (dump_ready) begin
            valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              state_d = ADDR;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign rs1_out    = busy ? idx_q : proc_rs1;
  assign dump_valid = valid_q;
  assign dump_reg   = reg_q;
  assign dump_data  = data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Randomised self-checking bench: default-parameter instance plus a SETTLE=3/NUM=4/FIRST=1 instance.
module tb_regfile_dump_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] regs [32];

  logic        a_start, a_abort, a_ready, a_valid, a_busy, a_done;
  logic [4:0]  a_proc, a_rs1, a_reg;
  logic [31:0] a_regA, a_data;

  logic        b_start, b_abort, b_ready, b_valid, b_busy, b_done;
  logic [4:0]  b_proc, b_rs1, b_reg;
  logic [31:0] b_regA, b_data;

  int checks = 0;
  int failures = 0;

  assign a_regA = regs[a_rs1];
  assign b_regA = regs[b_rs1];

  regfile_dump_ctrl dut_a (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .proc_rs1(a_proc), .rs1_out(a_rs1), .regA_in(a_regA),
    .dump_valid(a_valid), .dump_ready(a_ready), .dump_reg(a_reg),
    .dump_data(a_data), .busy(a_busy), .done(a_done)
  );

  regfile_dump_ctrl #(.NUM_REGS(4), .FIRST_REG(1), .SETTLE_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .proc_rs1(b_proc), .rs1_out(b_rs1), .regA_in(b_regA),
    .dump_valid(b_valid), .dump_ready(b_ready), .dump_reg(b_reg),
    .dump_data(b_data), .busy(b_busy), .done(b_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_start = 0; a_abort = 0; a_ready = 0; a_proc = 5'($urandom);
    b_start = 0; b_abort = 0; b_ready = 0; b_proc = 5'($urandom);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    reset = 1'b1;
    tick(); tick();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_reg !== 5'd0 || a_data !== 32'd0) begin failures++; $display("FAIL reset_beat got=%0d/%0h exp=0/0", a_reg, a_data); end
    checks++; if (a_rs1 !== a_proc) begin failures++; $display("FAIL reset_rs1 got=%0d exp=%0d", a_rs1, a_proc); end
    checks++; if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_rs1 !== b_proc) begin
      failures++; $display("FAIL reset_b got=v%b b%b rs1=%0d exp=v0 b0 rs1=%0d", b_valid, b_busy, b_rs1, b_proc);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    for (int v = 7; v <= 12; v++) begin
      a_proc = 5'(v);
      #1;
      checks++; if (a_rs1 !== 5'(v)) begin failures++; $display("FAIL passthru got=%0d exp=%0d", a_rs1, v); end
    end
    for (int k = 0; k < 4; k++) begin
      a_proc = 5'($urandom);
      tick();
      checks++; if (a_rs1 !== a_proc) begin failures++; $display("FAIL passthru_rand got=%0d exp=%0d", a_rs1, a_proc); end
    end
  endtask

  // Edge e counts from the start edge (e=1); default timing: 2 cycles per register.
  task automatic test_full_dump();
    logic       exp_busy, exp_valid, exp_done;
    logic [4:0] exp_rs1, exp_reg;
    int         done_seen = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    a_ready = 1; a_proc = 5'd7; a_start = 1;
    tick();
    a_start = 0;
    for (int e = 1; e <= 70; e++) begin
      if (e > 1) tick();
      exp_busy  = (e <= 64);
      exp_valid = (e >= 2 && e <= 64 && (e % 2) == 0);
      exp_done  = (e == 65);
      exp_rs1   = exp_busy ? 5'((e - 1) / 2) : 5'd7;
      exp_reg   = 5'((e - 2) / 2);
      if (a_done) done_seen++;
      checks++; if (a_busy !== exp_busy) begin failures++; $display("FAIL full_busy e=%0d got=%b exp=%b", e, a_busy, exp_busy); end
      checks++; if (a_valid !== exp_valid) begin failures++; $display("FAIL full_valid e=%0d got=%b exp=%b", e, a_valid, exp_valid); end
      checks++; if (a_done !== exp_done) begin failures++; $display("FAIL full_done e=%0d got=%b exp=%b", e, a_done, exp_done); end
      checks++; if (a_rs1 !== exp_rs1) begin failures++; $display("FAIL full_rs1 e=%0d got=%0d exp=%0d", e, a_rs1, exp_rs1); end
      if (exp_valid) begin
        checks++;
        if (a_reg !== exp_reg || a_data !== 32'(exp_reg) * 32'd3) begin
          failures++; $display("FAIL full_beat e=%0d got=%0d/%0d exp=%0d/%0d", e, a_reg, a_data, exp_reg, exp_reg * 3);
        end
      end
    end
    checks++; if (done_seen != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_seen); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  q_reg[$];
    logic [31:0] q_data[$];
    int stall_left = 3, done_cnt = 0, cyc = 0;
    logic prev_valid = 0, prev_ready = 0;
    logic [4:0] prev_reg = '0;
    for (int i = 0; i < 32; i++) begin regs[i] = 32'(i * 3); q_reg.push_back(5'(i)); q_data.push_back(32'(i * 3)); end
    a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    while (done_cnt == 0 && cyc < 600) begin
      tick(); cyc++;
      if (a_done) done_cnt++;
      if (prev_valid && !prev_ready) begin
        checks++; if (a_valid !== 1'b1 || a_reg !== prev_reg) begin
          failures++; $display("FAIL bp_hold got=v%b r%0d exp=v1 r%0d", a_valid, a_reg, prev_reg);
        end
      end
      if (a_valid) begin
        checks++;
        if (q_reg.size() == 0) begin
          failures++; $display("FAIL bp_extra_beat got=%0d exp=none", a_reg);
        end else if (a_reg !== q_reg[0] || a_data !== q_data[0]) begin
          failures++; $display("FAIL bp_beat got=%0d/%0d exp=%0d/%0d", a_reg, a_data, q_reg[0], q_data[0]);
        end
      end
      if (a_valid && a_reg == 5'd5 && stall_left > 0) begin
        a_ready = 0; stall_left--; regs[5] = $urandom;
      end else begin
        a_ready = ($urandom_range(0, 3) != 0);
      end
      if (a_valid && a_ready && q_reg.size() > 0) begin void'(q_reg.pop_front()); void'(q_data.pop_front()); end
      prev_valid = a_valid; prev_ready = a_ready; prev_reg = a_reg;
    end
    for (int k = 0; k < 3; k++) begin tick(); if (a_done) done_cnt++; end
    checks++; if (q_reg.size() != 0) begin failures++; $display("FAIL bp_left got=%0d exp=0", q_reg.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    checks++; if (stall_left != 0) begin failures++; $display("FAIL bp_stall_used got=%0d exp=0", stall_left); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%b exp=0", a_busy); end
    a_ready = 1;
  endtask

  task automatic test_start_ignored();
    logic [4:0]  q_reg[$];
    logic [31:0] q_data[$];
    int done_cnt = 0, cyc = 0;
    bit pulsed = 0;
    for (int i = 0; i < 32; i++) begin regs[i] = $urandom; q_reg.push_back(5'(i)); q_data.push_back(regs[i]); end
    a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    while (cyc < 200) begin
      tick(); cyc++;
      a_start = 0;
      if (a_done) done_cnt++;
      if (a_valid) begin
        checks++;
        if (q_reg.size() == 0) begin
          failures++; $display("FAIL restart_extra got=%0d exp=none", a_reg);
        end else begin
          if (a_reg !== q_reg[0] || a_data !== q_data[0]) begin
            failures++; $display("FAIL restart_beat got=%0d/%0h exp=%0d/%0h", a_reg, a_data, q_reg[0], q_data[0]);
          end
          void'(q_reg.pop_front()); void'(q_data.pop_front());
        end
        if (a_reg == 5'd4 && !pulsed) begin a_start = 1; pulsed = 1; end
      end
      if (done_cnt > 0 && cyc > 80) break;
    end
    checks++; if (q_reg.size() != 0) begin failures++; $display("FAIL restart_left got=%0d exp=0", q_reg.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL restart_busy_end got=%b exp=0", a_busy); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    a_ready = 1; a_start = 1;
    tick();
    a_start = 0;
    for (int e = 2; e <= 21; e++) tick();
    checks++; if (a_rs1 !== 5'd10 || a_valid !== 1'b0) begin
      failures++; $display("FAIL abort_setup got=rs1 %0d v%b exp=rs1 10 v0", a_rs1, a_valid);
    end
    a_abort = 1; a_proc = 5'($urandom);
    tick();
    a_abort = 0;
    checks++; if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=b%b v%b d%b exp=b0 v0 d0", a_busy, a_valid, a_done);
    end
    checks++; if (a_rs1 !== a_proc) begin failures++; $display("FAIL abort_rs1 got=%0d exp=%0d", a_rs1, a_proc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL abort_quiet got=d%b b%b exp=d0 b0", a_done, a_busy); end
    end
    a_start = 1; a_abort = 1;
    tick();
    a_start = 0; a_abort = 0;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL abort_wins got=%b exp=0", a_busy); end
    a_start = 1;
    tick();
    a_start = 0;
    checks++; if (a_busy !== 1'b1 || a_rs1 !== 5'd0) begin failures++; $display("FAIL restart_addr got=b%b rs1 %0d exp=b1 rs1 0", a_busy, a_rs1); end
    tick();
    checks++; if (a_valid !== 1'b1 || a_reg !== 5'd0 || a_data !== regs[0]) begin
      failures++; $display("FAIL restart_first got=v%b %0d/%0h exp=v1 0/%0h", a_valid, a_reg, a_data, regs[0]);
    end
    a_abort = 1;
    tick();
    a_abort = 0;
  endtask

  task automatic test_async_reset();
    a_ready = 0; a_start = 1;
    tick();
    a_start = 0;
    tick();
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL ar_setup got=%b exp=1", a_valid); end
    #3 reset = 1'b1;
    #1;
    checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL async_reset got=v%b b%b d%b exp=v0 b0 d0", a_valid, a_busy, a_done);
    end
    checks++; if (a_rs1 !== a_proc) begin failures++; $display("FAIL ar_rs1 got=%0d exp=%0d", a_rs1, a_proc); end
    reset = 1'b0;
    tick();
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL ar_after got=%b exp=0", a_busy); end
  endtask

  // SETTLE=3, regs 1..3: one beat every 4 cycles, first valid 4 edges after start.
  task automatic test_param_variant();
    logic       exp_busy, exp_valid, exp_done;
    logic [4:0] exp_rs1, exp_reg;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    b_proc = 5'($urandom); b_ready = 1; b_start = 1;
    tick();
    b_start = 0;
    for (int e = 1; e <= 16; e++) begin
      if (e > 1) tick();
      exp_busy  = (e <= 12);
      exp_valid = (e >= 4 && e <= 12 && (e % 4) == 0);
      exp_done  = (e == 13);
      exp_rs1   = exp_busy ? 5'(1 + (e - 1) / 4) : b_proc;
      exp_reg   = 5'(1 + (e - 4) / 4);
      checks++; if (b_busy !== exp_busy) begin failures++; $display("FAIL var_busy e=%0d got=%b exp=%b", e, b_busy, exp_busy); end
      checks++; if (b_valid !== exp_valid) begin failures++; $display("FAIL var_valid e=%0d got=%b exp=%b", e, b_valid, exp_valid); end
      checks++; if (b_done !== exp_done) begin failures++; $display("FAIL var_done e=%0d got=%b exp=%b", e, b_done, exp_done); end
      checks++; if (b_rs1 !== exp_rs1) begin failures++; $display("FAIL var_rs1 e=%0d got=%0d exp=%0d", e, b_rs1, exp_rs1); end
      if (exp_valid) begin
        checks++;
        if (b_reg !== exp_reg || b_data !== regs[exp_reg]) begin
          failures++; $display("FAIL var_beat e=%0d got=%0d/%0h exp=%0d/%0h", e, b_reg, b_data, exp_reg, regs[exp_reg]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full_dump();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_param_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
